// File: rtl/cp0_exception_unit_pkg.sv
// rtl/cp0_exception_unit_pkg.sv - CP0 register numbers, ExcCodes, field positions and write masks
package cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET_DEFAULT = 32'h0040_0000;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// rtl/cp0_exception_unit_timer.sv - Count/Compare pair, half-rate tick and timer interrupt flag
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      // A Compare write always wins over a coincident match, so TI ends cleared.
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 register file, M-stage exception/interrupt arbitration and redirect
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] STATUS_RESET = STATUS_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        adel_if_i,
  input  logic        adel_d_i,
  input  logic        ades_d_i,
  input  logic [31:0] data_addr_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o
);

  logic [31:0] status_q, epc_q, badvaddr_q;
  logic        bd_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exccode_q;
  logic [31:0] count, compare, cause;
  logic        ti;

  logic        int_pending, exc_valid, eret_taken, mtc0_we, bypass, badv_we;
  exc_code_e   exc_code;
  logic [31:0] badv_val;

  assign cause = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  assign int_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                       (|(cause[15:8] & status_q[15:8]));

  always_comb begin
    exc_valid = 1'b0;
    exc_code  = EXC_INT;
    badv_we   = 1'b0;
    badv_val  = data_addr_i;
    if (inst_valid_i) begin
      if (int_pending) begin
        exc_valid = 1'b1;
        exc_code  = EXC_INT;
      end else if (adel_if_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_ADEL;
        badv_we   = 1'b1;
        badv_val  = pc_i;
      end else if (ri_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_RI;
      end else if (ov_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_OV;
      end else if (syscall_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_SYS;
      end else if (break_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_BP;
      end else if (adel_d_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_ADEL;
        badv_we   = 1'b1;
      end else if (ades_d_i) begin
        exc_valid = 1'b1;
        exc_code  = EXC_ADES;
        badv_we   = 1'b1;
      end
    end
  end

  assign eret_taken = inst_valid_i & eret_i & ~exc_valid;
  // Flush is gated by reset so an in-flight exception vanishes the moment reset asserts.
  assign flush_o = resetn & (exc_valid | eret_taken);
  assign newpc_o = !resetn    ? 32'd0 :
                   exc_valid  ? EXC_VECTOR :
                   eret_taken ? epc_q : 32'd0;
  assign mtc0_we = we_i & ~(exc_valid | eret_taken);

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (mtc0_we && waddr_i == CP0_COUNT),
    .compare_we (mtc0_we && waddr_i == CP0_COMPARE),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RESET;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
    end else begin
      ip_hw_q <= {int_i[5] | ti, int_i[4:0]};
      if (exc_valid) begin
        status_q[STATUS_EXL] <= 1'b1;
        exccode_q            <= exc_code;
        // Nested exception: keep the original return point and BD.
        if (!status_q[STATUS_EXL]) begin
          bd_q  <= in_delayslot_i;
          epc_q <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
        end
        if (badv_we)
          badvaddr_q <= badv_val;
      end else if (eret_taken) begin
        status_q[STATUS_EXL] <= 1'b0;
      end else if (mtc0_we) begin
        case (waddr_i)
          CP0_STATUS: status_q <= wmerge(status_q, wdata_i, STATUS_WMASK);
          CP0_CAUSE:  ip_sw_q  <= wdata_i[9:8];
          CP0_EPC:    epc_q    <= wdata_i;
          default:    ;
        endcase
      end
    end
  end

  assign bypass = mtc0_we && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = bypass ? wdata_i : count;
      CP0_COMPARE:  rdata_o = bypass ? wdata_i : compare;
      CP0_STATUS:   rdata_o = bypass ? wmerge(status_q, wdata_i, STATUS_WMASK) : status_q;
      CP0_CAUSE:    rdata_o = bypass ? wmerge(cause, wdata_i, CAUSE_WMASK) : cause;
      CP0_EPC:      rdata_o = bypass ? wdata_i : epc_q;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign epc_o    = epc_q;
  assign status_o = status_q;
  assign cause_o  = cause;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed and randomized bench for cp0_exception_unit
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_valid_i, in_delayslot_i, syscall_i, break_i, eret_i, ri_i, ov_i;
  logic        adel_if_i, adel_d_i, ades_d_i, we_i, flush_o;
  logic [31:0] pc_i, data_addr_i, wdata_i, rdata_o, newpc_o, epc_o, status_o, cause_o;
  logic [5:0]  int_i;
  logic [4:0]  waddr_i, raddr_i;

  always #5 clk = ~clk;

  cp0_exception_unit dut (
    .clk(clk), .resetn(resetn), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .syscall_i(syscall_i), .break_i(break_i),
    .eret_i(eret_i), .ri_i(ri_i), .ov_i(ov_i), .adel_if_i(adel_if_i),
    .adel_d_i(adel_d_i), .ades_d_i(ades_d_i), .data_addr_i(data_addr_i),
    .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .flush_o(flush_o), .newpc_o(newpc_o),
    .epc_o(epc_o), .status_o(status_o), .cause_o(cause_o)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] PRIO_CODE [8] = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
  localparam logic [4:0] REG_PICK  [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd7};

  // Architectural model state
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic        m_bd, m_ti, m_tick;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw;
  logic [4:0]  m_exc;
  // Per-cycle model decisions
  logic        e_exc, e_eret, e_wr, e_flush, e_badv_set;
  logic [4:0]  e_code;
  logic [31:0] e_newpc, e_rdata, e_badv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_written(input logic [4:0] a, input logic [31:0] d);
    case (a)
      5'd8:    return m_badv;
      5'd12:   return (m_status & ~32'h0000_FF03) | (d & 32'h0000_FF03);
      5'd13:   return (m_cause() & ~32'h0000_0300) | (d & 32'h0000_0300);
      5'd9, 5'd11, 5'd14: return d;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
    m_bd = 0; m_ti = 0; m_tick = 0; m_ip_hw = 0; m_ip_sw = 0; m_exc = 0;
  endtask

  task automatic model_comb();
    bit hit [8];
    logic [31:0] c;
    c = m_cause();
    hit = '{m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 0),
            adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_d_i, ades_d_i};
    e_exc = 0; e_code = 0; e_badv_set = 0; e_badv = 0;
    if (inst_valid_i)
      for (int i = 0; i < 8; i++)
        if (!e_exc && hit[i]) begin
          e_exc = 1;
          e_code = PRIO_CODE[i];
          if (i == 1) begin e_badv_set = 1; e_badv = pc_i; end
          if (i >= 6) begin e_badv_set = 1; e_badv = data_addr_i; end
        end
    e_eret  = inst_valid_i && eret_i && !e_exc;
    e_flush = e_exc || e_eret;
    e_newpc = e_exc ? 32'hBFC0_0380 : (e_eret ? m_epc : 32'd0);
    e_wr    = we_i && !e_flush;
    e_rdata = (e_wr && waddr_i == raddr_i) ? m_written(raddr_i, wdata_i) : m_read(raddr_i);
  endtask

  task automatic model_seq();
    logic new_ti;
    new_ti = (e_wr && waddr_i == 5'd11) ? 1'b0 :
             (m_count == m_compare && m_compare != 0) ? 1'b1 : m_ti;
    m_ip_hw = {int_i[5] | m_ti, int_i[4:0]};
    m_ti = new_ti;
    if (e_wr && waddr_i == 5'd9) m_count = wdata_i;
    else if (m_tick) m_count = m_count + 1;
    m_tick = !m_tick;
    if (e_wr && waddr_i == 5'd11) m_compare = wdata_i;
    if (e_exc) begin
      if (!m_status[1]) begin
        m_bd  = in_delayslot_i;
        m_epc = in_delayslot_i ? pc_i - 4 : pc_i;
      end
      m_status[1] = 1'b1;
      m_exc = e_code;
      if (e_badv_set) m_badv = e_badv;
    end else if (e_eret) begin
      m_status[1] = 1'b0;
    end else if (e_wr) begin
      if (waddr_i == 5'd12) m_status = m_written(5'd12, wdata_i);
      if (waddr_i == 5'd13) m_ip_sw = wdata_i[9:8];
      if (waddr_i == 5'd14) m_epc = wdata_i;
    end
  endtask

  task automatic step();
    #1;
    model_comb();
    chk("flush", {31'd0, flush_o}, {31'd0, e_flush});
    chk("newpc", newpc_o, e_newpc);
    chk("rdata", rdata_o, e_rdata);
    chk("epc", epc_o, m_epc);
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause());
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clr();
    inst_valid_i = 0; pc_i = 0; in_delayslot_i = 0; syscall_i = 0; break_i = 0;
    eret_i = 0; ri_i = 0; ov_i = 0; adel_if_i = 0; adel_d_i = 0; ades_d_i = 0;
    data_addr_i = 0; int_i = 0; we_i = 0; waddr_i = 0; raddr_i = 0; wdata_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    clr(); we_i = 1; waddr_i = a; wdata_i = d;
    step();
  endtask

  initial begin
    int n;
    clr();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    raddr_i = 5'd12; #1;
    chk("rst_status_rd", rdata_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_newpc", newpc_o, 32'd0);
    raddr_i = 5'd9; #1;
    chk("rst_count", rdata_o, 32'd0);
    @(negedge clk);
    resetn = 1;

    repeat (10) step();
    raddr_i = 5'd9; #1;
    chk("count_after_10", rdata_o, 32'd5);

    // SYSCALL then ERET
    clr(); inst_valid_i = 1; pc_i = 32'hBFC0_0100; syscall_i = 1; #1;
    chk("sys_flush", {31'd0, flush_o}, 32'd1);
    chk("sys_newpc", newpc_o, 32'hBFC0_0380);
    step();
    clr(); #1;
    chk("sys_epc", epc_o, 32'hBFC0_0100);
    chk("sys_code", {27'd0, cause_o[6:2]}, 32'h08);
    chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
    inst_valid_i = 1; eret_i = 1; #1;
    chk("eret_newpc", newpc_o, 32'hBFC0_0100);
    step();
    clr(); #1;
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Delay-slot overflow
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0014; in_delayslot_i = 1; ov_i = 1;
    step();
    clr(); #1;
    chk("ds_epc", epc_o, 32'h8000_0010);
    chk("ds_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("ds_code", {27'd0, cause_o[6:2]}, 32'h0C);
    mtc0(5'd12, 32'd0);

    // Priority: ri over ov/syscall, then interrupt over all
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0020; ri_i = 1; ov_i = 1; syscall_i = 1;
    step();
    clr(); #1;
    chk("prio_ri", {27'd0, cause_o[6:2]}, 32'h0A);
    mtc0(5'd12, 32'd0);
    clr(); int_i = 6'd1; we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401;
    step();
    clr(); int_i = 6'd1; inst_valid_i = 1; pc_i = 32'h8000_0040; ri_i = 1; ov_i = 1; syscall_i = 1;
    step();
    clr(); #1;
    chk("prio_int", {27'd0, cause_o[6:2]}, 32'h00);
    mtc0(5'd12, 32'd0);

    // Timer interrupt
    mtc0(5'd9, 32'd10);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    clr(); raddr_i = 5'd9;
    n = 0;
    while (!m_ti && n < 60) begin step(); n++; end
    chk("ti_set", {31'd0, cause_o[30]}, 32'd1);
    step();
    chk("ip7_set", {31'd0, cause_o[15]}, 32'd1);
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0300; #1;
    chk("timer_flush", {31'd0, flush_o}, 32'd1);
    step();
    clr(); #1;
    chk("timer_code", {27'd0, cause_o[6:2]}, 32'h00);
    chk("timer_epc", epc_o, 32'h8000_0300);
    mtc0(5'd11, 32'd0);
    chk("ti_clear", {31'd0, cause_o[30]}, 32'd0);
    mtc0(5'd12, 32'd0);

    // ADES with dropped MTC0, then nested exception
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0100; ades_d_i = 1; data_addr_i = 32'h0000_1003;
    we_i = 1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    step();
    clr(); raddr_i = 5'd8; #1;
    chk("ades_badv", rdata_o, 32'h0000_1003);
    chk("ades_code", {27'd0, cause_o[6:2]}, 32'h05);
    chk("ades_mtc0_drop", status_o, 32'h0040_0002);
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0200; syscall_i = 1;
    step();
    clr(); #1;
    chk("nested_epc", epc_o, 32'h8000_0100);
    chk("nested_code", {27'd0, cause_o[6:2]}, 32'h08);
    mtc0(5'd12, 32'd0);

    // Randomized traffic against the model
    repeat (400) begin
      clr();
      inst_valid_i   = ($urandom_range(0, 3) != 0);
      pc_i           = $urandom & 32'hFFFF_FFFC;
      in_delayslot_i = $urandom_range(0, 1) == 1;
      syscall_i      = $urandom_range(0, 9) == 0;
      break_i        = $urandom_range(0, 9) == 0;
      eret_i         = $urandom_range(0, 5) == 0;
      ri_i           = $urandom_range(0, 9) == 0;
      ov_i           = $urandom_range(0, 9) == 0;
      adel_if_i      = $urandom_range(0, 11) == 0;
      adel_d_i       = $urandom_range(0, 11) == 0;
      ades_d_i       = $urandom_range(0, 11) == 0;
      data_addr_i    = $urandom;
      int_i          = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      we_i           = $urandom_range(0, 2) == 0;
      waddr_i        = REG_PICK[$urandom_range(0, 7)];
      raddr_i        = ($urandom_range(0, 3) == 0) ? waddr_i : REG_PICK[$urandom_range(0, 7)];
      wdata_i        = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      step();
    end

    // Reset asserted while an exception is being signalled
    clr(); inst_valid_i = 1; pc_i = 32'h8000_0400; syscall_i = 1; #1;
    chk("pre_rst_flush", {31'd0, flush_o}, 32'd1);
    resetn = 0; #1;
    chk("midrst_flush", {31'd0, flush_o}, 32'd0);
    chk("midrst_newpc", newpc_o, 32'd0);
    chk("midrst_status", status_o, 32'h0040_0000);
    chk("midrst_epc", epc_o, 32'd0);
    chk("midrst_cause", cause_o, 32'd0);
    model_reset();
    clr();
    @(negedge clk);
    resetn = 1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Consumer of the decoder's trap, privilege and invalid-instruction flags.
- Holds the CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC) and serves MFC0 reads and MTC0 writes.
- Arbitrates exceptions and interrupts for the instruction in the memory stage. Drives a one-cycle pipeline flush and a redirect PC.
- Sits beside the M stage; its flush goes to every pipeline register, its redirect PC goes to the fetch PC mux.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry address.
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1, everything else 0).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_valid_i  in  1  M-stage slot holds a real instruction (not a bubble or a flushed slot)
- pc_i  in  32  PC of the M-stage instruction
- in_delayslot_i  in  1  M-stage instruction sits in a branch delay slot
- syscall_i, break_i, eret_i, ri_i  in  1 each  decoder flags carried down to M
- ov_i  in  1  ALU overflow
- adel_if_i  in  1  misaligned fetch PC
- adel_d_i, ades_d_i  in  1 each  misaligned load / misaligned store
- data_addr_i  in  32  load/store effective address
- int_i  in  6  hardware interrupt lines, already synchronised
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 register number
- raddr_i  in  5  MFC0 register number
- wdata_i  in  32  MTC0 data
- rdata_o  out  32  MFC0 data
- flush_o  out  1  exception or ERET taken this cycle
- newpc_o  out  32  redirect target, valid while flush_o=1
- epc_o, status_o, cause_o  out  32 each  current register values for hazard logic

Behaviour:
- Reset (async on resetn=0): Status=STATUS_RESET; Cause, EPC, BadVAddr, Count, Compare and the tick toggle all 0; flush_o=0; newpc_o=0.
- Count increments by 1 every second clk (toggle bit) and wraps at 32'hFFFF_FFFF to 0.
- Timer interrupt: TI (Cause[30]) is set when Count==Compare and Compare!=0. TI is cleared by any MTC0 to Compare.
- Cause.IP[7:2] are sampled each cycle as int_i[5:0], with IP7 = int_i[5] | TI. Cause.IP[1:0] are software-writable.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).
- Exception evaluation is combinational and active only when inst_valid_i=1. Priority, highest first, with ExcCode:
  - interrupt 0x00
  - adel_if 0x04 (BadVAddr=pc_i)
  - ri 0x0A
  - ov 0x0C
  - syscall 0x08
  - break 0x09
  - adel_d 0x04 (BadVAddr=data_addr_i)
  - ades_d 0x05 (BadVAddr=data_addr_i)
  - eret (not an exception; handled as a return)
- Exception taken, updated on the next clock edge:
  - flush_o=1 and newpc_o=EXC_VECTOR in the same cycle (zero latency).
  - Status.EXL set; Cause.ExcCode set.
  - If EXL was already 1: EPC and Cause.BD are left unchanged.
  - Otherwise: Cause.BD=in_delayslot_i and EPC = in_delayslot_i ? pc_i-4 : pc_i.
- ERET taken: flush_o=1, newpc_o=EPC, Status.EXL cleared on the edge.
- MTC0 write masks:
  - Status: only IM[15:8], EXL[1], IE[0] are writable.
  - Cause: only IP[9:8] are writable.
  - BadVAddr: read-only.
  - Unimplemented register numbers: writes ignored, reads return 0.
- Simultaneous events:
  - Exception/ERET with we_i in the same cycle: the exception wins and the MTC0 write is dropped.
  - MTC0 to Count in an increment cycle: the write wins.
  - MTC0 to Compare in the same cycle as a Count==Compare hit: TI ends cleared.
- MFC0 read is combinational. It bypasses a same-cycle write to the same register, with the write mask applied.
- Reset asserted mid-exception: all state returns to reset values immediately and flush_o drops.

Decomposition:
- Shared package/header:
  - CP0 register numbers (8, 9, 11, 12, 13, 14)
  - ExcCode constants
  - Status and Cause field bit positions
  - EXC_VECTOR default
- One sub-module, cp0_timer: Count, Compare, tick toggle and TI generation.

Test Plan:
- Reset release: MFC0 12 returns 32'h0040_0000, Cause=0, Count=0; after 10 cycles Count=5.
- SYSCALL at pc 32'hBFC0_0100, not in delay slot, EXL=0: flush_o=1, newpc_o=32'hBFC0_0380; next cycle EPC=32'hBFC0_0100, ExcCode=0x08, EXL=1. A following ERET gives newpc_o=32'hBFC0_0100 and EXL=0.
- Delay-slot overflow at pc 32'h8000_0014: EPC=32'h8000_0010, Cause.BD=1, ExcCode=0x0C.
- Simultaneous ri_i and ov_i and syscall_i: ExcCode=0x0A. Repeat with int_i[0]=1, IM2=1, IE=1: ExcCode=0x00.
- Timer: write Compare=20, Status=32'h0000_8001; once Count reaches 20, Cause[30]=1 and IP7=1, and an interrupt is taken on the next valid instruction. A subsequent MTC0 Compare clears TI.
- ADES at data_addr_i=32'h0000_1003: BadVAddr=32'h0000_1003, ExcCode=0x05. An MTC0 to Status in the same cycle is dropped; an exception with EXL=1 already set leaves EPC unchanged.
